// File: rtl/ads_sample_packer_pkg.sv
// Shared ADS definitions: widths, FSM state encoding and the boxcar-average helper.
package ads_pkg;
  localparam int ADS_SMP_W = 16;
  localparam int PK_W      = 32;
  localparam int ACC_W     = 20;

  typedef enum logic {ST_IDLE, ST_RUN} ads_st_e;

  // Arithmetic shift rounds toward -inf; only the low sample-width bits are kept.
  function automatic logic [ADS_SMP_W-1:0] ads_avg(input logic signed [ACC_W-1:0] sum,
                                                   input int sh);
    return ADS_SMP_W'(sum >>> sh);
  endfunction
endpackage

// File: rtl/ads_sample_packer_if.sv
// Valid/ready word stream from the packer to the packet/transmit path.
interface ads_pk_if import ads_pkg::*; #(parameter int W = PK_W) ();
  logic [W-1:0] PK_DATA;
  logic         PK_VALID;
  logic         PK_READY;
  logic         PK_LAST;

  modport master (output PK_DATA, output PK_VALID, output PK_LAST, input PK_READY);
  modport slave  (input PK_DATA, input PK_VALID, input PK_LAST, output PK_READY);
endinterface

// File: rtl/ads_sample_packer_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees the slot a same-cycle push may use.
module ads_pk_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         wr_ok, rd_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_ok   = rd_en_i & ~empty_o;
  assign wr_ok   = wr_en_i & (~full_o | rd_ok);
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/ads_sample_packer.sv
// Boxcar-averages ADS8363 A/B samples, pairs them into 32-bit words and frames them
// into a FWFT FIFO for a valid/ready consumer.
module ads_sample_packer import ads_pkg::*; #(
  parameter int AVG_LOG2   = 2,
  parameter int FRAME_LEN  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 CLK_100M,
  input  logic                 CLK_RST_N,
  input  logic                 ADS_INIT_OK,
  input  logic                 FRAME_START,
  input  logic [ADS_SMP_W-1:0] ADS_ADATA,
  input  logic                 ADS_AVALID,
  input  logic [ADS_SMP_W-1:0] ADS_BDATA,
  input  logic                 ADS_BVALID,
  ads_pk_if.master             pk,
  output logic                 PK_OVF,
  output logic                 PK_PAIR_ERR,
  output logic                 PK_SHORT
);
  localparam int NAVG = 1 << AVG_LOG2;

  ads_st_e                 state_q, state_d;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, sum_a, sum_b;
  logic [4:0]              cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [ADS_SMP_W-1:0]    hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic                    rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [7:0]              wcnt_q, wcnt_d;
  logic                    ovf_q, ovf_d, perr_q, perr_d, short_q, short_d;
  logic                    act, clr, push, last, pop, fifo_full, fifo_empty;
  logic [PK_W:0]           fifo_out;

  assign sum_a = acc_a_q + ACC_W'($signed(ADS_ADATA));
  assign sum_b = acc_b_q + ACC_W'($signed(ADS_BDATA));
  // A restart or loss of INIT_OK takes precedence over any strobe in the same cycle.
  assign act   = (state_q == ST_RUN) & ADS_INIT_OK & ~FRAME_START;
  assign last  = (wcnt_q == 8'(FRAME_LEN-1));
  assign pop   = ~fifo_empty & pk.PK_READY;

  always_comb begin
    state_d  = state_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    rdy_a_d  = rdy_a_q;
    rdy_b_d  = rdy_b_q;
    wcnt_d   = wcnt_q;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    short_d  = short_q;
    clr      = 1'b0;
    push     = 1'b0;

    if (act & ADS_AVALID) begin
      if (cnt_a_q == 5'(NAVG-1)) begin
        hold_a_d = ads_avg(sum_a, AVG_LOG2);
        rdy_a_d  = 1'b1;
        perr_d   = perr_q | rdy_a_q;
        acc_a_d  = '0;
        cnt_a_d  = '0;
      end else begin
        acc_a_d = sum_a;
        cnt_a_d = cnt_a_q + 5'd1;
      end
    end
    if (act & ADS_BVALID) begin
      if (cnt_b_q == 5'(NAVG-1)) begin
        hold_b_d = ads_avg(sum_b, AVG_LOG2);
        rdy_b_d  = 1'b1;
        perr_d   = perr_d | rdy_b_q;
        acc_b_d  = '0;
        cnt_b_d  = '0;
      end else begin
        acc_b_d = sum_b;
        cnt_b_d = cnt_b_q + 5'd1;
      end
    end

    push = act & rdy_a_d & rdy_b_d;
    if (push) begin
      rdy_a_d = 1'b0;
      rdy_b_d = 1'b0;
      ovf_d   = ovf_q | (fifo_full & ~pop);
      if (last) begin
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE: if (FRAME_START & ADS_INIT_OK) begin
        state_d = ST_RUN;
        clr     = 1'b1;
      end
      ST_RUN: if (!ADS_INIT_OK) begin
        state_d = ST_IDLE;
        clr     = 1'b1;
      end else if (FRAME_START) begin
        short_d = 1'b1;
        clr     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      acc_a_d = '0;
      acc_b_d = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      rdy_a_d = 1'b0;
      rdy_b_d = 1'b0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (!CLK_RST_N) begin
      state_q  <= ST_IDLE;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      rdy_a_q  <= 1'b0;
      rdy_b_q  <= 1'b0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      rdy_a_q  <= rdy_a_d;
      rdy_b_q  <= rdy_b_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      short_q  <= short_d;
    end
  end

  ads_pk_fifo #(.W(PK_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK_100M),
    .rst_n     (CLK_RST_N),
    .wr_en_i   (push),
    .wr_data_i ({last, hold_a_d, hold_b_d}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pk.PK_DATA   = fifo_out[PK_W-1:0];
  assign pk.PK_LAST   = fifo_out[PK_W];
  assign pk.PK_VALID  = ~fifo_empty;
  assign PK_OVF       = ovf_q;
  assign PK_PAIR_ERR  = perr_q;
  assign PK_SHORT     = short_q;
endmodule
